// File: rtl/act_poly_unit.sv
// Fixed-point tanh/sigmoid unit: odd Taylor series by Horner on one shared multiplier.
// Latency: NTERMS+4 cycles on the series path, 3 on the saturation path (accept edge counted).
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
module act_poly_unit #(
    parameter int W      = 32,
    parameter int FRAC   = 26,
    parameter int NTERMS = 5,
    parameter int SAT_TH = 87241523
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ABS  = 3'd1;
    localparam logic [2:0] S_SQR  = 3'd2;
    localparam logic [2:0] S_HORN = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_SIGN = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // Coefficients are round(c * 2^FRAC); round(a/b) is taken as floor((2a+b)/(2b)).
    localparam longint         ONE_L   = longint'(1) <<< FRAC;
    localparam logic [W-1:0]   ONE     = W'(ONE_L);
    localparam logic [W-1:0]   HALF    = W'(ONE_L >>> 1);
    localparam logic [W-1:0]   C1      = ONE;
    localparam logic [W-1:0]   C3      = W'(-((2 * ONE_L + 3) / 6));
    localparam logic [W-1:0]   C5      = W'((4 * ONE_L + 15) / 30);
    localparam logic [W-1:0]   C7      = W'(-((34 * ONE_L + 315) / 630));
    localparam logic [W-1:0]   C9      = W'((124 * ONE_L + 2835) / 5670);
    localparam logic [W-1:0]   SAT_LIM = W'(SAT_TH);
    localparam logic [W-1:0]   MIN_NEG = {1'b1, {(W-1){1'b0}}};

    // Coefficient of term k (k=1 -> x, k=2 -> x^3, ... k=5 -> x^9).
    function automatic logic [W-1:0] coef(input logic [2:0] k);
        case (k)
            3'd1:    coef = C1;
            3'd2:    coef = C3;
            3'd3:    coef = C5;
            3'd4:    coef = C7;
            3'd5:    coef = C9;
            default: coef = '0;
        endcase
    endfunction

    logic [2:0]     state;
    logic [W-1:0]   x_r;
    logic           mode_r;
    logic           neg_r;
    logic [W-1:0]   u_r;
    logic [W-1:0]   u2_r;
    logic [W-1:0]   acc_r;
    logic [W-1:0]   mag_r;
    logic           sat_r;
    logic [2:0]     cnt_r;

    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_full;
    logic [W-1:0]   mul_q;
    logic           mul_unused;

    logic [W-1:0]   abs_x;
    logic [W-1:0]   u_abs;
    logic           sat_hit;
    logic [W-1:0]   t_val;
    logic [W-1:0]   res_val;

    assign in_ready = (state == S_IDLE);

    // Operand select for the single shared multiplier: u*u in SQR, acc*u in FIN, acc*u2 in HORN.
    always_comb begin
        mul_a = acc_r;
        mul_b = u2_r;
        case (state)
            S_SQR: begin
                mul_a = u_r;
                mul_b = u_r;
            end
            S_FIN: begin
                mul_a = acc_r;
                mul_b = u_r;
            end
            default: ;
        endcase
    end

    // Both operands are sign-extended so the low 2W bits hold the signed product;
    // taking bits [FRAC+W-1:FRAC] is an arithmetic shift (floor) truncated to W.
    assign mul_full   = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
    assign mul_q      = mul_full[FRAC+W-1:FRAC];
    assign mul_unused = ^{mul_full[2*W-1:FRAC+W], mul_full[FRAC-1:0]};

    // Magnitude and saturation decision; sigmoid evaluates tanh(x/2), hence the halving.
    always_comb begin
        abs_x   = x_r[W-1] ? -x_r : x_r;
        u_abs   = mode_r ? {abs_x[W-1], abs_x[W-1:1]} : abs_x;
        sat_hit = (x_r == MIN_NEG) || ($signed(u_abs) > $signed(SAT_LIM));
    end

    // Sign restore and output mapping; sigmoid(x) = 1/2 + tanh(x/2)/2.
    always_comb begin
        t_val   = neg_r ? -mag_r : mag_r;
        res_val = mode_r ? (HALF + {t_val[W-1], t_val[W-1:1]}) : t_val;
    end

    // Sequencer and datapath registers; flush aborts to IDLE but keeps the last out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            x_r       <= '0;
            mode_r    <= 1'b0;
            neg_r     <= 1'b0;
            u_r       <= '0;
            u2_r      <= '0;
            acc_r     <= '0;
            mag_r     <= '0;
            sat_r     <= 1'b0;
            cnt_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r    <= in_data;
                        mode_r <= in_mode;
                        state  <= S_ABS;
                    end
                end
                S_ABS: begin
                    neg_r <= x_r[W-1];
                    u_r   <= u_abs;
                    if (sat_hit) begin
                        mag_r <= ONE;
                        sat_r <= 1'b1;
                        state <= S_SIGN;
                    end else begin
                        sat_r <= 1'b0;
                        state <= S_SQR;
                    end
                end
                S_SQR: begin
                    u2_r  <= mul_q;
                    acc_r <= coef(3'(NTERMS));
                    cnt_r <= 3'(NTERMS - 1);
                    state <= S_HORN;
                end
                S_HORN: begin
                    acc_r <= coef(cnt_r) + mul_q;
                    if (cnt_r == 3'd1) begin
                        state <= S_FIN;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                S_FIN: begin
                    mag_r <= mul_q;
                    state <= S_SIGN;
                end
                S_SIGN: begin
                    out_data  <= res_val;
                    out_sat   <= sat_r;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_poly_unit.sv
// Self-checking bench for act_poly_unit: directed scenarios plus randomized transactions
// against a plain-arithmetic series model.
module tb_act_poly_unit;

    localparam logic [31:0] ONE    = 32'h04000000;
    localparam longint      SAT_TH = 87241523;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] r_half;

    act_poly_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Q6.26 product, floored and truncated to 32 bits.
    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = (a * b) >>> 26;
        return longint'(int'(p));
    endfunction

    // Reference: tanh by five-term odd series, sigmoid as 1/2 + tanh(x/2)/2, saturation above 1.3.
    function automatic void ref_act(input logic [31:0] x, input logic mode,
                                    output logic [31:0] res, output logic sat, output int lat);
        longint coefs[5];
        longint xv, u, u2, acc, mag, t;
        coefs = '{67108864, -22369621, 8947849, -3621748, 1467637};
        xv  = longint'($signed(x));
        sat = (x == 32'h80000000);
        u   = (xv < 0) ? -xv : xv;
        if (mode) u = u / 2;
        if (u > SAT_TH) sat = 1'b1;
        if (sat) begin
            mag = longint'(ONE);
        end else begin
            u2  = mulq(u, u);
            acc = coefs[4];
            for (int k = 3; k >= 0; k--) acc = coefs[k] + mulq(acc, u2);
            mag = mulq(acc, u);
        end
        t   = (xv < 0) ? -mag : mag;
        res = mode ? 32'(longint'(ONE) / 2 + (t >>> 1)) : 32'(t);
        lat = sat ? 3 : 9;
    endfunction

    // Issue one request and wait for out_valid; lat counts edges, the accept edge being 1.
    // Busy-time inputs are scrambled to show they are ignored.
    task automatic run_txn(input logic [31:0] x, input logic m,
                           output logic [31:0] d, output logic s, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        @(posedge clk);
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_mode  = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
        end
        in_valid = 1'b0;
        d = out_data;
        s = out_sat;
    endtask

    task automatic collect;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_tanh_basic;
        logic [31:0] d, ed, neg_exp;
        logic s, es;
        int lat, el, diff;
        ref_act(32'h02000000, 1'b0, ed, es, el);
        run_txn(32'h02000000, 1'b0, d, s, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL tanh_half_latency got=%0d want=9", lat); end
        total++; if (d !== ed) begin bad++; $display("FAIL tanh_half_data got=%0d want=%0d", d, ed); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL tanh_half_sat got=%b want=0", s); end
        // True tanh(0.5) is 31012157 LSB; the truncated series sits a few hundred LSB above it.
        diff = int'(d) - 31012157;
        total++; if (diff < 0 || diff > 300) begin bad++; $display("FAIL tanh_half_accuracy got=%0d want=31012157..31012457", d); end
        collect();
        r_half = d;
        neg_exp = -r_half;
        run_txn(32'hFE000000, 1'b0, d, s, lat);
        total++; if (d !== neg_exp) begin bad++; $display("FAIL tanh_neg_half_data got=%h want=%h", d, neg_exp); end
        total++; if (lat !== 9 || s !== 1'b0) begin bad++; $display("FAIL tanh_neg_half_lat_sat got=%0d/%b want=9/0", lat, s); end
        collect();
    endtask

    task automatic test_saturate;
        logic [31:0] tx[8], td[8];
        logic tm[8], ts[8], use_model[8];
        int tl[8];
        logic [31:0] d, ed;
        logic s, es;
        int lat, el;
        tx = '{32'h08000000, 32'h80000000, 32'h05333333, 32'h05333334,
               32'hFACCCCCC, 32'h0A666666, 32'h0A666668, 32'h80000000};
        tm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        td = '{32'h04000000, 32'hFC000000, 32'h0, 32'h04000000,
               32'hFC000000, 32'h0, 32'h04000000, 32'h00000000};
        ts = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tl = '{3, 3, 9, 3, 3, 9, 3, 3};
        use_model = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            ref_act(tx[i], tm[i], ed, es, el);
            if (!use_model[i]) ed = td[i];
            run_txn(tx[i], tm[i], d, s, lat);
            total++; if (d !== ed) begin bad++; $display("FAIL sat_case%0d_data x=%h got=%h want=%h", i, tx[i], d, ed); end
            total++; if (s !== ts[i]) begin bad++; $display("FAIL sat_case%0d_flag got=%b want=%b", i, s, ts[i]); end
            total++; if (lat !== tl[i]) begin bad++; $display("FAIL sat_case%0d_latency got=%0d want=%0d", i, lat, tl[i]); end
            collect();
        end
    endtask

    task automatic test_sigmoid;
        logic [31:0] tx[3], td[3];
        logic ts[3];
        int tl[3];
        logic [31:0] d;
        logic s;
        int lat;
        tx = '{32'h00000000, 32'h0C000000, 32'hF4000000};
        td = '{32'h02000000, 32'h04000000, 32'h00000000};
        ts = '{1'b0, 1'b1, 1'b1};
        tl = '{9, 3, 3};
        for (int i = 0; i < 3; i++) begin
            run_txn(tx[i], 1'b1, d, s, lat);
            total++; if (d !== td[i] || s !== ts[i]) begin bad++; $display("FAIL sigmoid_case%0d got=%h/%b want=%h/%b", i, d, s, td[i], ts[i]); end
            total++; if (lat !== tl[i]) begin bad++; $display("FAIL sigmoid_case%0d_latency got=%0d want=%0d", i, lat, tl[i]); end
            collect();
        end
    endtask

    task automatic test_random;
        logic [31:0] x, d, ed;
        logic m, s, es;
        int lat, el;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) x = $urandom;
            else x = $urandom_range(0, m ? 32'h0C000000 : 32'h06000000);
            if ($urandom_range(0, 1) == 1) x = -x;
            ref_act(x, m, ed, es, el);
            run_txn(x, m, d, s, lat);
            total++; if (d !== ed) begin bad++; $display("FAIL rand%0d_data x=%h mode=%b got=%h want=%h", i, x, m, d, ed); end
            total++; if (s !== es) begin bad++; $display("FAIL rand%0d_sat x=%h got=%b want=%b", i, x, s, es); end
            total++; if (lat !== el) begin bad++; $display("FAIL rand%0d_latency x=%h got=%0d want=%0d", i, x, lat, el); end
            collect();
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d, ed;
        logic s, es;
        int lat, el;
        ref_act(32'h01000000, 1'b0, ed, es, el);
        run_txn(32'h01000000, 1'b0, d, s, lat);
        total++; if (d !== ed) begin bad++; $display("FAIL bp_data got=%h want=%h", d, ed); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== ed || out_sat !== es || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b d=%h s=%b rdy=%b want v=1 d=%h s=%b rdy=0",
                         i, out_valid, out_data, out_sat, in_ready, ed, es);
            end
        end
        collect();
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_flush_reset;
        logic [31:0] d;
        logic s, seen;
        int lat;
        // Flush while the series is in the Horner loop.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h02000000; in_mode = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_horn got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_dropped got out_valid=1 want 0"); end
        // Flush a pending result: valid and sat drop, data is kept.
        run_txn(32'h08000000, 1'b0, d, s, lat);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_sat !== 1'b0 || out_data !== ONE || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_done got v=%b s=%b d=%h rdy=%b want v=0 s=0 d=%h rdy=1", out_valid, out_sat, out_data, in_ready, ONE);
        end
        // Asynchronous reset in the middle of DONE.
        run_txn(32'hFE000000, 1'b0, d, s, lat);
        total++; if (out_valid !== 1'b1 || lat !== 9) begin bad++; $display("FAIL pre_reset got v=%b lat=%0d want v=1 lat=9", out_valid, lat); end
        #2 rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got v=%b rdy=%b d=%h s=%b want v=0 rdy=1 d=0 s=0", out_valid, in_ready, out_data, out_sat);
        end
        @(negedge clk);
        rst = 1'b1;
        run_txn(32'h02000000, 1'b0, d, s, lat);
        total++; if (d !== r_half || s !== 1'b0 || lat !== 9) begin bad++; $display("FAIL after_reset got d=%h s=%b lat=%0d want d=%h s=0 lat=9", d, s, lat, r_half); end
        collect();
    endtask

    initial begin
        test_reset();
        test_tanh_basic();
        test_saturate();
        test_sigmoid();
        test_random();
        test_backpressure();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
